// File: rtl/tick_pkg.sv
// Shared types and defaults for the tick scheduler and its channels.
package tick_pkg;

  // Config port FSM: IDLE accepts a request, PENDING waits until it can be applied.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  localparam int NCH_DEFAULT = 4;
  localparam int PW_DEFAULT  = 16;

  // Channel-select width; a single channel still gets a one-bit select.
  function automatic int chan_sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One periodic tick channel: period register, interval counter and registered strobe.
module tick_channel
  import tick_pkg::*;
#(
  parameter int PW = PW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          sync,
  output logic          tick,
  output logic          active,
  output logic          wrap
);

  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_m1_s;
  logic          tick_q, tick_d;
  logic          active_q, active_d;

  // Wrap flag: the current cycle is the last one of an interval on an active channel.
  always_comb begin
    per_m1_s = {PW{1'b0}};
    if (active_q) begin
      per_m1_s = per_q - PW'(1'b1);
    end else begin
      per_m1_s = {PW{1'b0}};
    end
    wrap = active_q && (cnt_q == per_m1_s);
  end

  // Next state: sync restarts the interval, a load lands on a boundary, else count.
  always_comb begin
    per_d    = per_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (sync) begin
      cnt_d  = {PW{1'b0}};
      tick_d = 1'b0;
    end else if (load) begin
      // A load on an active channel coincides with its wrap, so the old tick still fires.
      per_d    = load_val;
      active_d = (load_val != {PW{1'b0}});
      cnt_d    = {PW{1'b0}};
      tick_d   = wrap;
    end else if (active_q) begin
      if (wrap) begin
        cnt_d  = {PW{1'b0}};
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + PW'(1'b1);
        tick_d = 1'b0;
      end
    end else begin
      cnt_d  = {PW{1'b0}};
      tick_d = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_q    <= {PW{1'b0}};
      cnt_q    <= {PW{1'b0}};
      tick_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      per_q    <= per_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      active_q <= active_d;
    end
  end

  assign tick   = tick_q;
  assign active = active_q;

endmodule

// File: rtl/tick_scheduler.sv
// NCH-channel clock-enable scheduler with a valid/ready period config port.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter  int NCH = NCH_DEFAULT,
  parameter  int PW  = PW_DEFAULT,
  localparam int CW  = chan_sel_width(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           sync,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] active
);

  cfg_state_t     state_q;
  logic           ready_q;
  logic [CW-1:0]  ch_q;
  logic [PW-1:0]  period_q;

  logic [NCH-1:0] load_s;
  logic [NCH-1:0] wrap_s;
  logic [NCH-1:0] active_s;
  logic           apply_s;
  logic           valid_ch_s;

  // Decode the pending target and decide whether its new period lands on this edge.
  always_comb begin
    load_s     = {NCH{1'b0}};
    apply_s    = 1'b0;
    valid_ch_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CW'(i)) begin
        valid_ch_s = 1'b1;
        // Inactive targets take the update at once; active ones only at their wrap.
        if ((state_q == PENDING) && !sync && (!active_s[i] || wrap_s[i])) begin
          load_s[i] = 1'b1;
          apply_s   = 1'b1;
        end else begin
          load_s[i] = 1'b0;
        end
      end else begin
        load_s[i] = 1'b0;
      end
    end
  end

  // Config FSM: accept in IDLE, hold the request in PENDING until it is applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      ch_q     <= {CW{1'b0}};
      period_q <= {PW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid && ready_q) begin
            state_q  <= PENDING;
            ready_q  <= 1'b0;
            ch_q     <= cfg_ch;
            period_q <= cfg_period;
          end else begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
          end
        end
        PENDING: begin
          // An out-of-range channel is dropped after one cycle.
          if (!valid_ch_s || apply_s) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q <= PENDING;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .PW(PW)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s[g]),
      .load_val (period_q),
      .sync     (sync),
      .tick     (tick[g]),
      .active   (active_s[g]),
      .wrap     (wrap_s[g])
    );
  end

  assign cfg_ready = ready_q;
  assign active    = active_s;

endmodule
